bs_turn_ctrl: RTL
=================

// Module: bs_turn_ctrl
// PURPOSE
//  Parametrised Battleship game/turn controller for the Master board. It sits between the
//  debounced player switch/button inputs and the UART/display logic. Latches both fleets,
//  alternates A/B turns, accepts only single-new-cell attacks, scores hits, enforces an
//  optional turn timeout and declares the winner.
// PARAMETERS
//  CELLS        16        board cells per player (one switch per cell)
//  SHIP_CELLS   7         required ship cells per fleet (popcount checked at load)
//  TIMEOUT_CYC  0         cycles allowed per turn; 0 disables the timeout
//  (derived) IDX_W=$clog2(CELLS), CNT_W=$clog2(CELLS+1), TMR_W=$clog2(TIMEOUT_CYC+1)
// PORTS
//  clk         in   1       system clock; all state on rising edge
//  clr_n       in   1       asynchronous active-low reset
//  clear       in   1       synchronous game abort (BTN3), any state -> LOAD
//  start       in   1       load-confirm pulse (BTN1), 1 cycle, debounced upstream
//  fleet_a     in   CELLS   player A ship map (switches)
//  fleet_b     in   CELLS   player B ship map (switches)
//  sel_a       in   CELLS   player A cumulative target switches
//  sel_b       in   CELLS   player B cumulative target switches
//  fire_a      in   1       player A attack pulse (BTN2A)
//  fire_b      in   1       player B attack pulse (BTN2B)
//  turn_a      out  1       A may fire (state TURN_A)
//  turn_b      out  1       B may fire (state TURN_B)
//  shot_valid  out  1       1-cycle pulse: accepted shot reported
//  shot_plyr   out  1       0=A fired, 1=B fired (valid with shot_valid)
//  shot_idx    out  IDX_W   cell index of accepted shot
//  shot_hit    out  1       accepted shot struck an opponent ship cell
//  shots_a     out  CELLS   cells A has fired at (on B's board)
//  shots_b     out  CELLS   cells B has fired at
//  remain_a    out  CNT_W   A's unsunk ship cells
//  remain_b    out  CNT_W   B's unsunk ship cells
//  err_load    out  1       1-cycle pulse: fleet popcount != SHIP_CELLS on start
//  err_shot    out  1       1-cycle pulse: active player's new-cell count != 1
//  err_turn    out  1       1-cycle pulse: inactive player pressed fire
//  tmo         out  1       1-cycle pulse: turn forfeited by timeout
//  game_over   out  1       high in DONE
//  winner      out  1       0=A, 1=B; valid while game_over
// BEHAVIOUR
//  Reset/clear: state LOAD; all outputs 0; shots_*=0; remain_*=0; timer=0. clear wins over all.
//  LOAD: on start, both popcounts == SHIP_CELLS -> latch fleets, remain_*=SHIP_CELLS, -> TURN_A;
//    else err_load, stay. Fire ignored, no err_turn.
//  TURN_x: new = sel_x & ~shots_x (retracted switches ignored).
//    fire_x & popcount(new)==1 -> shots_x|=new; hit=fleet_opp[idx]; remain_opp-=hit; -> RESULT_x.
//    fire_x & popcount(new)!=1 -> err_shot, stay, timer kept.
//    fire from other player -> err_turn; if both fire same cycle, active player processed.
//    Timer counts every TURN cycle; at TIMEOUT_CYC-1 without valid fire: tmo, -> TURN_other.
//  RESULT_x (1 cycle): shot_valid/plyr/idx/hit asserted; remain_opp==0 -> DONE
//    (winner=x), else -> TURN_other; timer cleared on entry to every TURN.
//  Latency: fire edge -> shot_valid next cycle; fire accepted at most once per 2 cycles.
//  DONE: hold all maps/counters; ignore fire/start; exit only via clear or clr_n.
//  Fleets frozen after LOAD; switch changes ignored. remain never underflows, since shots are unique.
//  clr_n asserted mid-turn: immediate LOAD, partial shot discarded.
// STRUCTURE
//  bs_pkg: state_t enum {LOAD,TURN_A,RESULT_A,TURN_B,RESULT_B,DONE}; popcount and
//    onehot-to-index functions; PLYR_A/PLYR_B constants.
//  Sub-module bs_shot_decode #(CELLS): combinational; sel, shots -> one_new, idx, popcount.
//    Two instances, one per player.
// TESTING
//  1 Fleets 16'hE606 / 16'h30E6, start -> TURN_A, remain_a=remain_b=7, turn_a=1.
//  2 Fleet A popcount 6, start -> err_load pulse, state stays LOAD.
//  3 TURN_A, sel_a=16'h8000, fire_a -> next cycle shot_valid, idx=15, hit=0; then turn_b=1.
//  4 TURN_A, sel_a adds 2 new bits, fire_a -> err_shot; fire_b meanwhile -> err_turn; no shot.
//  5 B hits all 7 cells of 16'hE606 -> remain_a=0, game_over=1, winner=1; further fire ignored.
//  6 TIMEOUT_CYC=8, idle in TURN_A 8 cycles -> tmo pulse, turn_b; clear mid-game -> LOAD.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and helpers for the Battleship turn controller: FSM state encoding,
// player constants and the bit-counting functions used on ship and target maps.
package bs_pkg;

  // Widest board the helper functions accept; callers zero-extend into this width.
  localparam int MAX_CELLS = 64;

  localparam logic PLYR_A = 1'b0;
  localparam logic PLYR_B = 1'b1;

  typedef enum logic [2:0] {
    LOAD,
    TURN_A,
    RESULT_A,
    TURN_B,
    RESULT_B,
    DONE
  } state_t;

  function automatic int popcount(input logic [MAX_CELLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CELLS; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Only meaningful for a one-hot argument; returns the highest set bit otherwise.
  function automatic int onehot_to_index(input logic [MAX_CELLS-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_CELLS; i++) begin
      if (v[i]) begin
        r = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bs_shot_decode.sv
// Finds the cells a player has newly selected (switches up, not yet fired at) and
// reports whether exactly one such cell exists, its index and the new-cell count.
module bs_shot_decode
  import bs_pkg::*;
#(
  parameter  int CELLS = 16,
  localparam int IDX_W = $clog2(CELLS),
  localparam int CNT_W = $clog2(CELLS + 1)
) (
  input  logic [CELLS-1:0] sel,
  input  logic [CELLS-1:0] shots,
  output logic             one_new,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] new_cnt
);

  logic [CELLS-1:0] new_bits;

  // A switch left up after its shot, or pulled back down, never creates a new target.
  assign new_bits = sel & ~shots;
  assign new_cnt  = CNT_W'(popcount(MAX_CELLS'(new_bits)));
  assign one_new  = (new_cnt == CNT_W'(1));
  assign idx      = IDX_W'(onehot_to_index(MAX_CELLS'(new_bits)));

endmodule

// File: rtl/bs_turn_ctrl.sv
// Battleship game/turn controller: latches both fleets, alternates A/B turns,
// accepts single-new-cell attacks, scores hits, optional turn timeout, winner.
module bs_turn_ctrl
  import bs_pkg::*;
#(
  parameter  int CELLS       = 16,
  parameter  int SHIP_CELLS  = 7,
  parameter  int TIMEOUT_CYC = 0,
  localparam int IDX_W       = $clog2(CELLS),
  localparam int CNT_W       = $clog2(CELLS + 1),
  localparam int TMR_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             start,
  input  logic [CELLS-1:0] fleet_a,
  input  logic [CELLS-1:0] fleet_b,
  input  logic [CELLS-1:0] sel_a,
  input  logic [CELLS-1:0] sel_b,
  input  logic             fire_a,
  input  logic             fire_b,
  output logic             turn_a,
  output logic             turn_b,
  output logic             shot_valid,
  output logic             shot_plyr,
  output logic [IDX_W-1:0] shot_idx,
  output logic             shot_hit,
  output logic [CELLS-1:0] shots_a,
  output logic [CELLS-1:0] shots_b,
  output logic [CNT_W-1:0] remain_a,
  output logic [CNT_W-1:0] remain_b,
  output logic             err_load,
  output logic             err_shot,
  output logic             err_turn,
  output logic             tmo,
  output logic             game_over,
  output logic             winner
);

  state_t state, state_n;

  logic [CELLS-1:0] fleet_a_q, fleet_b_q;
  logic [TMR_W-1:0] timer;
  logic             shot_plyr_q, shot_hit_q, winner_q;
  logic [IDX_W-1:0] shot_idx_q;

  logic             one_new_a, one_new_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  bs_shot_decode #(.CELLS(CELLS)) u_dec_a (
    .sel     (sel_a),
    .shots   (shots_a),
    .one_new (one_new_a),
    .idx     (idx_a),
    .new_cnt (cnt_a)
  );

  bs_shot_decode #(.CELLS(CELLS)) u_dec_b (
    .sel     (sel_b),
    .shots   (shots_b),
    .one_new (one_new_b),
    .idx     (idx_b),
    .new_cnt (cnt_b)
  );

  // Everything below is viewed from the player whose turn it is.
  logic             act_b, act_fire, other_fire, act_one, act_hit, timer_hit;
  logic [IDX_W-1:0] act_idx;
  logic [CNT_W-1:0] act_cnt;
  logic [CELLS-1:0] act_cell;

  assign act_b      = (state == TURN_B);
  assign act_fire   = act_b ? fire_b : fire_a;
  assign other_fire = act_b ? fire_a : fire_b;
  assign act_one    = act_b ? one_new_b : one_new_a;
  assign act_idx    = act_b ? idx_b : idx_a;
  assign act_cnt    = act_b ? cnt_b : cnt_a;
  assign act_hit    = act_b ? fleet_a_q[act_idx] : fleet_b_q[act_idx];
  assign act_cell   = CELLS'(1) << act_idx;
  assign timer_hit  = (TIMEOUT_CYC > 0) && (timer == TMR_W'(TIMEOUT_CYC - 1));

  logic load_ok, load_bad, accept, bad_shot, wrong_turn, timeout;

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    load_ok    = 1'b0;
    load_bad   = 1'b0;
    accept     = 1'b0;
    bad_shot   = 1'b0;
    wrong_turn = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      LOAD: begin
        if (start) begin
          if (popcount(MAX_CELLS'(fleet_a)) == SHIP_CELLS &&
              popcount(MAX_CELLS'(fleet_b)) == SHIP_CELLS) begin
            load_ok = 1'b1;
            state_n = TURN_A;
          end else begin
            load_bad = 1'b1;
          end
        end
      end
      TURN_A, TURN_B: begin
        wrong_turn = other_fire;
        if (act_fire && act_one) begin
          accept  = 1'b1;
          state_n = act_b ? RESULT_B : RESULT_A;
        end else begin
          bad_shot = act_fire && (act_cnt != CNT_W'(1));
          if (timer_hit) begin
            timeout = 1'b1;
            state_n = act_b ? TURN_A : TURN_B;
          end
        end
      end
      RESULT_A: state_n = (remain_b == '0) ? DONE : TURN_B;
      RESULT_B: state_n = (remain_a == '0) ? DONE : TURN_A;
      DONE:     state_n = DONE;
      default:  state_n = LOAD;
    endcase
    if (clear) begin
      state_n = LOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= LOAD;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fleet_a_q   <= '0;
      fleet_b_q   <= '0;
      shots_a     <= '0;
      shots_b     <= '0;
      remain_a    <= '0;
      remain_b    <= '0;
      timer       <= '0;
      shot_plyr_q <= 1'b0;
      shot_idx_q  <= '0;
      shot_hit_q  <= 1'b0;
      winner_q    <= 1'b0;
      err_load    <= 1'b0;
      err_shot    <= 1'b0;
      err_turn    <= 1'b0;
      tmo         <= 1'b0;
    end else if (clear) begin
      fleet_a_q   <= '0;
      fleet_b_q   <= '0;
      shots_a     <= '0;
      shots_b     <= '0;
      remain_a    <= '0;
      remain_b    <= '0;
      timer       <= '0;
      shot_plyr_q <= 1'b0;
      shot_idx_q  <= '0;
      shot_hit_q  <= 1'b0;
      winner_q    <= 1'b0;
      err_load    <= 1'b0;
      err_shot    <= 1'b0;
      err_turn    <= 1'b0;
      tmo         <= 1'b0;
    end else begin
      err_load <= load_bad;
      err_shot <= bad_shot;
      err_turn <= wrong_turn;
      tmo      <= timeout;

      if (load_ok) begin
        fleet_a_q <= fleet_a;
        fleet_b_q <= fleet_b;
        remain_a  <= CNT_W'(SHIP_CELLS);
        remain_b  <= CNT_W'(SHIP_CELLS);
      end

      // Shots are unique cells, so a remain counter is decremented at most once per ship cell.
      if (accept) begin
        shot_plyr_q <= act_b;
        shot_idx_q  <= act_idx;
        shot_hit_q  <= act_hit;
        if (act_b) begin
          shots_b  <= shots_b | act_cell;
          remain_a <= remain_a - CNT_W'(act_hit);
        end else begin
          shots_a  <= shots_a | act_cell;
          remain_b <= remain_b - CNT_W'(act_hit);
        end
      end

      // Restarts on every entry into a turn, keeps running across rejected shots.
      if ((state == TURN_A || state == TURN_B) && state_n == state) begin
        timer <= timer + TMR_W'(1);
      end else begin
        timer <= '0;
      end

      if (state == RESULT_A && remain_b == '0) begin
        winner_q <= PLYR_A;
      end else if (state == RESULT_B && remain_a == '0) begin
        winner_q <= PLYR_B;
      end
    end
  end

  assign turn_a     = (state == TURN_A);
  assign turn_b     = (state == TURN_B);
  assign shot_valid = (state == RESULT_A) || (state == RESULT_B);
  assign shot_plyr  = shot_plyr_q;
  assign shot_idx   = shot_idx_q;
  assign shot_hit   = shot_hit_q;
  assign game_over  = (state == DONE);
  assign winner     = winner_q;

endmodule
